// File: rtl/cube_pkg.sv
// Shared definitions for the LED-cube write controller: command codes and FSM states.
package cube_pkg;

  localparam logic [7:0] CUBE_CMD_ADDR_WR   = 8'hcc;
  localparam logic [7:0] CUBE_CMD_DATA_WR   = 8'hda;
  localparam logic [7:0] CUBE_CMD_LAYER_SEL = 8'hce;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_LSEL = 2'd2,
    ST_DATA = 2'd3
  } state_e;

endpackage

// File: rtl/cube_write_ctl.sv
// Decodes a command/data byte stream into pixel addresses, colour byte enables
// and layer masks for writing a frame into the cube's pixel memories.
module cube_write_ctl
  import cube_pkg::*;
#(
  parameter int         LAYERS        = 8,
  parameter int         PIXELS        = 64,
  parameter int         COLORS        = 3,
  parameter logic [7:0] CMD_ADDR_WR   = CUBE_CMD_ADDR_WR,
  parameter logic [7:0] CMD_DATA_WR   = CUBE_CMD_DATA_WR,
  parameter logic [7:0] CMD_LAYER_SEL = CUBE_CMD_LAYER_SEL,
  localparam int        AW            = $clog2(PIXELS)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              dc_in,
  input  logic              byte_rdy_in,
  input  logic [7:0]        byte_data_in,
  output logic [AW-1:0]     wr_addr_out,
  output logic [COLORS:0]   byte_en_out,
  output logic [LAYERS-1:0] layer_en_out,
  output logic              frame_rdy_out,
  output logic              frame_err_out,
  output logic              busy_out
);

  localparam int              SW          = $clog2(LAYERS);
  localparam logic [COLORS:0] ADDR_EN     = (COLORS+1)'(1) << COLORS;
  localparam logic [COLORS:0] COLOR_FIRST = (COLORS+1)'(1) << (COLORS-1);
  localparam logic [AW-1:0]   LAST_PIXEL  = AW'(PIXELS-1);

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [COLORS:0]   byte_en_q, byte_en_d;
  logic [LAYERS-1:0] layer_q, layer_d;
  logic [SW-1:0]     start_q, start_d;
  logic              seen_q, seen_d;
  logic              frame_rdy_q, frame_rdy_d;
  logic              frame_err_q, frame_err_d;
  logic [COLORS-1:0] col, col_rot;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_IDLE;
      wr_addr_q   <= '0;
      byte_en_q   <= '0;
      layer_q     <= '0;
      start_q     <= SW'(LAYERS-1);
      seen_q      <= 1'b0;
      frame_rdy_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      byte_en_q   <= byte_en_d;
      layer_q     <= layer_d;
      start_q     <= start_d;
      seen_q      <= seen_d;
      frame_rdy_q <= frame_rdy_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    byte_en_d   = byte_en_q;
    layer_d     = layer_q;
    start_d     = start_q;
    seen_d      = seen_q;
    frame_rdy_d = 1'b0;
    frame_err_d = 1'b0;
    col         = byte_en_q[COLORS-1:0];
    col_rot     = (col >> 1) | (COLORS'(col[0]) << (COLORS-1));

    if (byte_rdy_in) begin
      if (!dc_in) begin
        // seen_q marks a data frame in progress, so any command mid-frame aborts it
        wr_addr_d = '0;
        seen_d    = 1'b0;
        if (state_q == ST_DATA && seen_q) frame_err_d = 1'b1;
        case (byte_data_in)
          CMD_ADDR_WR: begin
            state_d   = ST_ADDR;
            layer_d   = '1;
            byte_en_d = ADDR_EN;
          end
          CMD_LAYER_SEL: state_d = ST_LSEL;
          CMD_DATA_WR: begin
            state_d   = ST_DATA;
            layer_d   = LAYERS'(1) << start_q;
            byte_en_d = COLOR_FIRST;
          end
          default: ;
        endcase
      end else begin
        case (state_q)
          ST_ADDR: begin
            if (wr_addr_q == LAST_PIXEL) begin
              wr_addr_d = '0;
              layer_d   = '0;
              state_d   = ST_IDLE;
            end else begin
              wr_addr_d = wr_addr_q + AW'(1);
            end
          end
          ST_LSEL: begin
            start_d = SW'(byte_data_in % 8'(LAYERS));
            state_d = ST_IDLE;
          end
          ST_DATA: begin
            seen_d    = 1'b1;
            byte_en_d = {byte_en_q[COLORS], col_rot};
            // A pixel is done once its last colour byte has been taken
            if (col[0]) begin
              if (wr_addr_q == LAST_PIXEL) begin
                wr_addr_d = '0;
                if (layer_q[0]) begin
                  layer_d     = '0;
                  state_d     = ST_IDLE;
                  frame_rdy_d = 1'b1;
                  seen_d      = 1'b0;
                end else begin
                  layer_d = {layer_q[0], layer_q[LAYERS-1:1]};
                end
              end else begin
                wr_addr_d = wr_addr_q + AW'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign wr_addr_out   = wr_addr_q;
  assign byte_en_out   = byte_en_q;
  assign layer_en_out  = layer_q & {LAYERS{byte_rdy_in}};
  assign frame_rdy_out = frame_rdy_q;
  assign frame_err_out = frame_err_q;
  assign busy_out      = (state_q == ST_ADDR) || (state_q == ST_DATA);

endmodule

// File: tb/tb_cube_write_ctl.sv
// Randomized bench for cube_write_ctl against a pixel/colour/layer position model.
module tb_cube_write_ctl;

   localparam int LAYERS = 8;
   localparam int PIXELS = 64;
   localparam int COLORS = 3;
   localparam int AW = 6;
   localparam int FRAME_LAYER_BYTES = PIXELS * COLORS;

   logic clock = 1'b0;
   logic rst_n_in;
   logic dc_in;
   logic byte_rdy_in;
   logic [7:0] byte_data_in;
   logic [AW-1:0] wr_addr_out;
   logic [COLORS:0] byte_en_out;
   logic [LAYERS-1:0] layer_en_out;
   logic frame_rdy_out;
   logic frame_err_out;
   logic busy_out;

   int compared = 0;
   int mismatched = 0;

   // Model: mode 0 idle, 1 address load, 2 layer select, 3 frame data
   int mMode, mAddr, mCol, mAddrEn, mMask, mStart, mSeen, mRdy, mErr;
   int rdyPulses = 0;
   int errPulses = 0;
   int lastLayerEn = 0;

   cube_write_ctl #(.LAYERS(LAYERS), .PIXELS(PIXELS), .COLORS(COLORS)) dut (
      .clk_in(clock),
      .rst_n_in(rst_n_in),
      .dc_in(dc_in),
      .byte_rdy_in(byte_rdy_in),
      .byte_data_in(byte_data_in),
      .wr_addr_out(wr_addr_out),
      .byte_en_out(byte_en_out),
      .layer_en_out(layer_en_out),
      .frame_rdy_out(frame_rdy_out),
      .frame_err_out(frame_err_out),
      .busy_out(busy_out)
   );

   // Free-running 100 MHz clock
   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] obs, input int exp);
      compared++;
      if (obs !== 32'(exp)) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Model returns to its power-on picture of the controller
   task automatic modelReset();
      mMode = 0; mAddr = 0; mCol = -1; mAddrEn = 0; mMask = 0;
      mStart = LAYERS - 1; mSeen = 0; mRdy = 0; mErr = 0;
   endtask

   function automatic int expByteEn();
      return (mAddrEn << COLORS) | ((mCol >= 0) ? (1 << (COLORS - 1 - mCol)) : 0);
   endfunction

   // Advance the model by one accepted byte using pixel/colour/layer positions
   task automatic modelStep(input int dc, input int b);
      mRdy = 0;
      mErr = 0;
      if (dc == 0) begin
         mAddr = 0;
         if (mMode == 3 && mSeen != 0) mErr = 1;
         mSeen = 0;
         if (b == 'hcc) begin
            mMode = 1; mMask = (1 << LAYERS) - 1; mAddrEn = 1; mCol = -1;
         end else if (b == 'hce) begin
            mMode = 2;
         end else if (b == 'hda) begin
            mMode = 3; mMask = 1 << mStart; mAddrEn = 0; mCol = 0;
         end
      end else if (mMode == 1) begin
         if (mAddr == PIXELS - 1) begin
            mAddr = 0; mMask = 0; mMode = 0;
         end else begin
            mAddr++;
         end
      end else if (mMode == 2) begin
         mStart = b % LAYERS;
         mMode = 0;
      end else if (mMode == 3) begin
         mSeen = 1;
         if (mCol == COLORS - 1) begin
            mCol = 0;
            if (mAddr == PIXELS - 1) begin
               mAddr = 0;
               if (mMask == 1) begin
                  mMask = 0; mMode = 0; mRdy = 1; mSeen = 0;
               end else begin
                  mMask = mMask >> 1;
               end
            end else begin
               mAddr++;
            end
         end else begin
            mCol++;
         end
      end
   endtask

   // Compares every registered output (strobe low) with the model
   task automatic checkState(input string tag);
      checkOutput({tag, ".addr"}, 32'(wr_addr_out), mAddr);
      checkOutput({tag, ".byte_en"}, 32'(byte_en_out), expByteEn());
      checkOutput({tag, ".layer_en_idle"}, 32'(layer_en_out), 0);
      checkOutput({tag, ".frame_rdy"}, 32'(frame_rdy_out), mRdy);
      checkOutput({tag, ".frame_err"}, 32'(frame_err_out), mErr);
      checkOutput({tag, ".busy"}, 32'(busy_out), (mMode == 1 || mMode == 3) ? 1 : 0);
   endtask

   // One strobed byte: layer mask checked while strobed, registers after the edge
   task automatic applyStimulus(input int dc, input int b);
      @(negedge clock);
      dc_in = 1'(dc);
      byte_data_in = 8'(b);
      byte_rdy_in = 1'b1;
      #1;
      lastLayerEn = int'(layer_en_out);
      checkOutput("layer_en", 32'(layer_en_out), mMask);
      @(posedge clock);
      modelStep(dc, b);
      #1 byte_rdy_in = 1'b0;
      #1 checkState("byte");
      if (frame_rdy_out) rdyPulses++;
      if (frame_err_out) errPulses++;
   endtask

   // Cycle with the strobe low and garbage on the data lines
   task automatic idleCycle();
      @(negedge clock);
      dc_in = 1'($urandom);
      byte_data_in = 8'($urandom);
      byte_rdy_in = 1'b0;
      @(posedge clock);
      mRdy = 0;
      mErr = 0;
      #2 checkState("idle");
   endtask

   // Directed scenarios first, then a randomized command/data mix
   initial begin
      int r0, e0, pick;
      rst_n_in = 1'b0;
      dc_in = 1'b0;
      byte_rdy_in = 1'b0;
      byte_data_in = 8'h00;
      modelReset();
      repeat (3) @(posedge clock);
      #1 checkState("reset");
      @(negedge clock) rst_n_in = 1'b1;

      // Address load: 0..63 then wrap
      applyStimulus(0, 'hcc);
      for (int i = 0; i < PIXELS; i++) applyStimulus(1, int'($urandom_range(255)));
      checkOutput("addr_wrap", 32'(wr_addr_out), 0);
      checkOutput("addr_idle", 32'(busy_out), 0);
      idleCycle();

      // Full frame from the default top layer
      r0 = rdyPulses;
      applyStimulus(0, 'hda);
      for (int k = 0; k < LAYERS * FRAME_LAYER_BYTES; k++) begin
         applyStimulus(1, int'($urandom_range(255)));
         checkOutput("frame_layer", 32'(lastLayerEn), 'h80 >> (k / FRAME_LAYER_BYTES));
      end
      checkOutput("frame_rdy_last", 32'(frame_rdy_out), 1);
      idleCycle();
      checkOutput("frame_rdy_count", 32'(rdyPulses - r0), 1);

      // Start layer 3: only four layers written
      r0 = rdyPulses;
      applyStimulus(0, 'hce);
      applyStimulus(1, 'h03);
      applyStimulus(0, 'hda);
      for (int k = 0; k < 4 * FRAME_LAYER_BYTES; k++) begin
         applyStimulus(1, int'($urandom_range(255)));
         checkOutput("lsel_layer", 32'(lastLayerEn), 'h08 >> (k / FRAME_LAYER_BYTES));
      end
      idleCycle();
      checkOutput("lsel_rdy_count", 32'(rdyPulses - r0), 1);

      // Aborted frame
      e0 = errPulses;
      applyStimulus(0, 'hda);
      for (int k = 0; k < 100; k++) applyStimulus(1, int'($urandom_range(255)));
      applyStimulus(0, 'hcc);
      checkOutput("abort_byte_en", 32'(byte_en_out), 'b1000);
      checkOutput("abort_addr", 32'(wr_addr_out), 0);
      idleCycle();
      checkOutput("abort_err_count", 32'(errPulses - e0), 1);

      // Reset in the middle of a frame
      applyStimulus(0, 'hce);
      applyStimulus(1, 'h05);
      applyStimulus(0, 'hda);
      for (int k = 0; k < 500; k++) applyStimulus(1, int'($urandom_range(255)));
      @(negedge clock) rst_n_in = 1'b0;
      modelReset();
      #1 checkState("async_reset");
      repeat (2) idleCycle();
      @(negedge clock) rst_n_in = 1'b1;
      applyStimulus(0, 'hda);
      applyStimulus(1, 'h11);
      checkOutput("reset_start_layer", 32'(lastLayerEn), 'h80);

      // Random mix of commands, data and gaps
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(3) == 0) begin
            idleCycle();
         end else if ($urandom_range(7) == 0) begin
            pick = int'($urandom_range(3));
            case (pick)
               0: applyStimulus(0, 'hcc);
               1: applyStimulus(0, 'hce);
               2: applyStimulus(0, 'hda);
               default: applyStimulus(0, int'($urandom_range(255)));
            endcase
         end else begin
            applyStimulus(1, int'($urandom_range(255)));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
